fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
// - Shares the single 8-bit FIFO write port between N_REQ producers (ADC channels, host bridge).
// - Fair round-robin grant; one word per grant.
// - Holds push/din stable until the FIFO's slow capture edge (fifo_stb), so each grant yields exactly one push.
// - Back-pressures on full; reports commit and stall counts for debug.
// PARAMETERS
// N_REQ    4    number of requesters (2..8)
// DW       8    data width, equals FIFO din width
// CNT_W    16   width of commit/stall counters
// PORTS
// clk         in   1          system clock
// rst_n       in   1          reset, asynchronous, active-high (reset asserted while rst_n = 1)
// req_valid   in   N_REQ      requester i has a word on req_data
// req_data    in   N_REQ*DW   word i at [i*DW +: DW]
// req_mask    in   N_REQ      1 = requester i eligible for grant
// req_ack     out  N_REQ      one-clk pulse: word i committed to FIFO
// fifo_stb    in   1          high in the clk cycle whose closing edge is the FIFO capture edge
// fifo_full   in   1          FIFO full flag, sampled only when fifo_stb = 1
// fifo_push   out  1          to FIFO push_in
// fifo_din    out  DW         to FIFO din
// grant_id    out  $clog2(N_REQ)  index of the current or last grant
// busy        out  1          1 when state != IDLE
// commit_cnt  out  CNT_W      words pushed; saturates at all-ones
// stall_cnt   out  CNT_W      strobes lost to full; saturates at all-ones
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, rr pointer 0. Counters are cleared only by reset.
// - FSM states: IDLE, HOLD, ACK.
// - IDLE: eligible = req_valid & req_mask.
//   - If eligible != 0, pick the first set bit at or after the rr pointer (wrapping N_REQ-1 -> 0).
//   - Next edge: latch the data into fifo_din, set grant_id, fifo_push = 1, go to HOLD.
//   - If eligible == 0, stay in IDLE with fifo_push = 0.
// - HOLD: fifo_push = 1, fifo_din frozen.
//   - fifo_stb = 1 and fifo_full = 0 -> next edge: fifo_push = 0, req_ack[grant_id] = 1,
//     commit_cnt + 1, rr pointer = grant_id + 1 (mod N_REQ), go to ACK.
//   - fifo_stb = 1 and fifo_full = 1 -> stall_cnt + 1. Stay in HOLD with the same grant and data;
//     no re-arbitration.
//   - fifo_stb = 0 -> stay in HOLD.
// - ACK: single cycle. req_ack is high only in this cycle; go to IDLE.
//   - This gives the requester one edge to update req_valid/req_data before re-arbitration.
// - Latency: from valid in IDLE to ack is 1 + (clk cycles until the first non-full strobe) + 1.
//   The minimum is 3 clk when fifo_stb is already high in the first HOLD cycle.
// - At most one fifo_push per grant. fifo_push is never high in IDLE or ACK.
// - req_valid or req_mask dropping during HOLD is ignored: the latched word is still pushed and acked.
// - fifo_stb while in IDLE or ACK has no effect.
// - Reset asserted mid-HOLD: fifo_push drops asynchronously; the word is discarded and not acked.
// - Counter increments stop at 2^CNT_W-1 (no wrap).
// STRUCTURE
// - Package fifo_arb_pkg: state encoding (IDLE = 2'd0, HOLD = 2'd1, ACK = 2'd2) and the grant-index width.
// - Sub-module rr_pick: combinational round-robin picker.
//   - Inputs: eligible[N_REQ], ptr.
//   - Outputs: found, idx.
//   - Instantiated once. FSM, data latch and counters stay in fifo_wr_arbiter.
// TESTING
// 1. Reset: rst_n = 1 for 3 clk with req_valid = 4'hF.
//    -> fifo_push = 0, req_ack = 0, counters 0, busy = 0 throughout.
// 2. Single req: req_valid = 4'b0100, data2 = 8'hA5, fifo_stb every 10 clk, full = 0.
//    -> fifo_push high until the next strobe edge; fifo_din = 8'hA5.
//    -> exactly one push; req_ack = 4'b0100 for one clk; commit_cnt = 1.
// 3. All four valid continuously, data i = 8'h10 + i.
//    -> grant order 0,1,2,3,0; pushed words 10,11,12,13,10; commit_cnt = 5 after 5 strobes.
// 4. Full back-pressure: grant req1, fifo_full = 1 for 3 strobes, then 0.
//    -> stall_cnt = 3; fifo_din unchanged; grant_id = 1 kept; single push on strobe 4; one ack.
// 5. Mask: req_valid = 4'hF, req_mask = 4'b1010.
//    -> grants alternate 1,3,1,3; req_ack[0] and req_ack[2] never pulse.
// 6. Reset mid-HOLD: assert rst_n one clk before a strobe.
//    -> fifo_push = 0 immediately; no ack; after release, first grant is from pointer 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and
// the helper that sizes the grant index.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Grant index width; a single requester still gets a 1-bit index.
  function automatic int grant_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle for fifo_wr_arbiter.
//
// Handshake: a requester offers word i while req_valid[i] = 1 and req_mask[i] = 1.
// The arbiter latches one offered word and holds fifo_push/fifo_din steady until
// a cycle with fifo_stb = 1 and fifo_full = 0. The closing edge of that cycle is
// the FIFO capture edge. The arbiter then pulses req_ack[i] for exactly one clk,
// and the requester may update req_valid/req_data on that same edge.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_mask;
  logic [N_REQ-1:0]    req_ack;
  logic                fifo_stb;
  logic                fifo_full;
  logic                fifo_push;
  logic [DW-1:0]       fifo_din;

  modport master (
    input  req_valid, req_data, req_mask, fifo_stb, fifo_full,
    output req_ack, fifo_push, fifo_din
  );

  modport slave (
    output req_valid, req_data, req_mask, fifo_stb, fifo_full,
    input  req_ack, fifo_push, fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after
// ptr, wrapping from N_REQ-1 back to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = grant_w(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [GW-1:0]    ptr,
  output logic             found,
  output logic [GW-1:0]    idx
);

  logic [GW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = (cand == GW'(N_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// One word per grant, held on the port until the FIFO's slow capture strobe.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int CNT_W = 16,
  localparam int GW   = grant_w(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_wr_arbiter_if.master   bus,
  output logic [GW-1:0]       grant_id,
  output logic                busy,
  output logic [CNT_W-1:0]    commit_cnt,
  output logic [CNT_W-1:0]    stall_cnt,
  output state_t              state
);

  logic [GW-1:0]    rr_ptr;
  logic [N_REQ-1:0] eligible;
  logic             pick_found;
  logic [GW-1:0]    pick_idx;

  assign eligible = bus.req_valid & bus.req_mask;
  assign busy     = (state != IDLE);

  rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // rst_n is an active-high asynchronous reset; an in-flight word is dropped.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      bus.fifo_push <= 1'b0;
      bus.fifo_din  <= '0;
      bus.req_ack   <= '0;
      commit_cnt    <= '0;
      stall_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ack <= '0;
          if (pick_found) begin
            bus.fifo_din  <= bus.req_data[pick_idx*DW +: DW];
            grant_id      <= pick_idx;
            bus.fifo_push <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          // Grant and data stay frozen until a non-full strobe commits the word.
          if (bus.fifo_stb && !bus.fifo_full) begin
            bus.fifo_push         <= 1'b0;
            bus.req_ack           <= '0;
            bus.req_ack[grant_id] <= 1'b1;
            if (commit_cnt != '1) commit_cnt <= commit_cnt + 1'b1;
            rr_ptr <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            state  <= ACK;
          end else if (bus.fifo_stb && bus.fifo_full) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
          end
        end
        ACK: begin
          bus.req_ack <= '0;
          state       <= IDLE;
        end
        default: begin
          bus.fifo_push <= 1'b0;
          bus.req_ack   <= '0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: stimulus queues the expected {grant, word}
// for each commit; a negedge monitor matches FIFO captures and ack pulses.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int GW = 2;
  localparam int W  = GW + DW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

  logic [GW-1:0] grant_id;
  logic          busy;
  logic [CW-1:0] commit_cnt;
  logic [CW-1:0] stall_cnt;
  state_t        state;

  fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy),
    .commit_cnt (commit_cnt),
    .stall_cnt  (stall_cnt),
    .state      (state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  int            total = 0;
  int            bad   = 0;
  logic [GW-1:0] last_id = '0;
  bit            ack_pending = 1'b0;
  logic [W-1:0]  exp_item;
  logic [N-1:0]  exp_ack;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: FIFO captures at the close of a strobe cycle, ack one clk later.
  always @(negedge clk) begin
    if (rst_n) begin
      ack_pending = 1'b0;
    end else begin
      if (ack_pending) begin
        exp_ack = '0;
        exp_ack[last_id] = 1'b1;
        chk("req_ack_pulse", 32'(bus.req_ack), 32'(exp_ack));
        ack_pending = 1'b0;
      end else begin
        chk("req_ack_idle", 32'(bus.req_ack), 32'd0);
      end
      if (state != HOLD) chk("push_outside_hold", 32'(bus.fifo_push), 32'd0);
      if (bus.fifo_push && bus.fifo_stb && !bus.fifo_full) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL push_unexpected: got id=%0d din=%0h expected no push", grant_id, bus.fifo_din);
        end else begin
          exp_item = exp_q.pop_front();
          chk("push_word", 32'({grant_id, bus.fifo_din}), 32'(exp_item));
        end
        last_id     = grant_id;
        ack_pending = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_strobe(input int gap, input bit full);
    if (gap > 0) tick(gap);
    bus.fifo_stb  = 1'b1;
    bus.fifo_full = full;
    tick(1);
    bus.fifo_stb  = 1'b0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic wait_hold();
    int n = 0;
    while (state != HOLD && n < 40) begin
      tick(1);
      n++;
    end
    chk("wait_hold_timeout", 32'(state == HOLD), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick(2);
    rst_n = 1'b0;
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = base + 8'(i);
  endtask

  function automatic logic [W-1:0] item(input int id, input logic [7:0] d);
    return {GW'(id), d};
  endfunction

  int exp_order3[5] = '{0, 1, 2, 3, 0};
  int exp_order5[4] = '{1, 3, 1, 3};

  initial begin
    bus.req_valid = 4'hF;
    bus.req_mask  = 4'hF;
    bus.req_data  = '0;
    bus.fifo_stb  = 1'b0;
    bus.fifo_full = 1'b0;

    // 1. reset held with all requesters valid
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_push_ack_busy", 32'({bus.fifo_push, bus.req_ack, busy}), 32'd0);
      chk("reset_counters", {commit_cnt, stall_cnt}, 32'd0);
    end
    @(posedge clk); #1;

    // 2. single requester 2, strobe every 10 clk
    set_data(8'h00);
    bus.req_data[2*DW +: DW] = 8'hA5;
    bus.req_valid = 4'b0100;
    exp_q.push_back(item(2, 8'hA5));
    rst_n = 1'b0;
    tick(1);
    @(negedge clk);
    chk("single_state_hold", 32'(state), 32'(HOLD));
    chk("single_push_din", 32'({bus.fifo_push, bus.fifo_din}), 32'h1A5);
    chk("single_grant_busy", 32'({grant_id, busy}), 32'b101);
    do_strobe(9, 1'b0);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("single_ack", 32'(bus.req_ack), 32'b0100);
    chk("single_commit", 32'(commit_cnt), 32'd1);
    do_strobe(3, 1'b0);
    do_strobe(9, 1'b0);
    @(negedge clk);
    chk("single_no_repush", 32'({bus.fifo_push, busy}), 32'd0);
    chk("single_commit_stays", 32'(commit_cnt), 32'd1);

    // 3. all four valid, fresh pointer
    set_data(8'h10);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) exp_q.push_back(item(exp_order3[k], 8'h10 + 8'(exp_order3[k])));
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wait_hold();
      chk("rr_grant_order", 32'(grant_id), 32'(exp_order3[k]));
      do_strobe(0, 1'b0);
      if (k == 4) bus.req_valid = 4'h0;
    end
    @(negedge clk);
    chk("rr_commit5", {commit_cnt, stall_cnt}, {16'd5, 16'd0});

    // 4. full back-pressure on requester 1; request withdrawn during HOLD
    bus.req_data[1*DW +: DW] = 8'h5C;
    bus.req_valid = 4'b0010;
    exp_q.push_back(item(1, 8'h5C));
    wait_hold();
    chk("full_grant", 32'(grant_id), 32'd1);
    do_strobe(0, 1'b1);
    bus.req_valid = 4'b0000;
    bus.req_data[1*DW +: DW] = 8'hFF;
    do_strobe(2, 1'b1);
    do_strobe(2, 1'b1);
    @(negedge clk);
    chk("full_stall3", 32'(stall_cnt), 32'd3);
    chk("full_held", 32'({state, bus.fifo_push, grant_id, bus.fifo_din}), 32'({HOLD, 1'b1, 2'd1, 8'h5C}));
    do_strobe(2, 1'b0);
    @(negedge clk);
    chk("full_commit", {commit_cnt, stall_cnt}, {16'd6, 16'd3});

    // 5. mask 1010 with all valid, fresh pointer
    set_data(8'h20);
    bus.req_mask  = 4'b1010;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 4; k++) exp_q.push_back(item(exp_order5[k], 8'h20 + 8'(exp_order5[k])));
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_hold();
      chk("mask_grant_order", 32'(grant_id), 32'(exp_order5[k]));
      do_strobe(1, 1'b0);
    end
    @(negedge clk);
    chk("mask_commit4", 32'(commit_cnt), 32'd4);

    // 6. advance pointer to 3, then reset in the middle of HOLD
    bus.req_mask = 4'b0100;
    exp_q.push_back(item(2, 8'h22));
    wait_hold();
    chk("pre_reset_grant2", 32'(grant_id), 32'd2);
    do_strobe(0, 1'b0);
    bus.req_mask = 4'hF;
    wait_hold();
    chk("pre_reset_grant3", 32'(grant_id), 32'd3);
    rst_n = 1'b1;
    #1;
    chk("midhold_reset_async", 32'({bus.fifo_push, busy, bus.req_ack}), 32'd0);
    tick(1);
    bus.fifo_stb = 1'b1;
    tick(1);
    bus.fifo_stb = 1'b0;
    exp_q.push_back(item(0, 8'h20));
    rst_n = 1'b0;
    wait_hold();
    chk("post_reset_grant0", 32'(grant_id), 32'd0);
    do_strobe(0, 1'b0);
    @(negedge clk);
    chk("post_reset_counters", {commit_cnt, stall_cnt}, {16'd1, 16'd0});

    tick(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule
